// File: rtl/menu_pkg.sv
// rtl/menu_pkg.sv - screen encodings and default sizes shared by menu_ctrl and its key front end
package menu_pkg;

  typedef enum logic [1:0] {
    SCR_MENU  = 2'd0,
    SCR_GAME  = 2'd1,
    SCR_PAUSE = 2'd2,
    SCR_OVER  = 2'd3
  } screen_e;

  localparam logic [1:0] ITEM_START = 2'd0;

  localparam int N_ITEMS_DEF      = 3;
  localparam int OVER_HOLD_DEF    = 180;
  localparam int REPEAT_DELAY_DEF = 30;
  localparam int REPEAT_RATE_DEF  = 6;

endpackage

// File: rtl/menu_key_edge.sv
// rtl/menu_key_edge.sv - press detect and frame-pending flag for one key; auto-repeat under MENU_KEY_REPEAT_EN
module menu_key_edge
`ifdef MENU_KEY_REPEAT_EN
#(
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_RATE  = 6,
  parameter bit CAN_REPEAT   = 1'b0
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  input  logic tick_i,
`ifdef MENU_KEY_REPEAT_EN
  input  logic menu_i,
`endif
  output logic pend_o
);

  logic key_q;
  logic pend_q, pend_d;
  logic press;

  // A press landing in the tick cycle survives the clear and waits for the next frame.
  assign press  = key_i & ~key_q;
  assign pend_d = tick_i ? press : (pend_q | press);

  always_ff @(posedge clk) begin
    if (!rst) begin
      key_q  <= 1'b1;
      pend_q <= 1'b0;
    end else begin
      key_q  <= key_i;
      pend_q <= pend_d;
    end
  end

`ifdef MENU_KEY_REPEAT_EN
  localparam int CW = $clog2(REPEAT_DELAY + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          fire;

  // Synthetic press is injected straight into the tick it belongs to.
  assign fire = CAN_REPEAT & tick_i & menu_i & key_i & (cnt_q == CW'(REPEAT_DELAY - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!key_i) begin
      cnt_d = '0;
    end else if (fire) begin
      cnt_d = CW'(REPEAT_DELAY - REPEAT_RATE);
    end else if (tick_i && (cnt_q != CW'(REPEAT_DELAY - 1))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign pend_o = pend_q | fire;
`else
  assign pend_o = pend_q;
`endif

endmodule

// File: rtl/menu_ctrl.sv
// rtl/menu_ctrl.sv - frame-synchronous menu/game/pause/over sequencer; MENU_KEY_REPEAT_EN enables up/down auto-repeat
module menu_ctrl
  import menu_pkg::*;
#(
  parameter int N_ITEMS   = N_ITEMS_DEF,
  parameter int OVER_HOLD = OVER_HOLD_DEF
`ifdef MENU_KEY_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk_in,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_enter,
  input  logic       key_esc,
  input  logic       game_over,
  output logic [1:0] screen_sel,
  output logic [1:0] item_sel,
  output logic       game_en,
  output logic       game_rst,
  output logic       item_act
);

  localparam int         OW        = $clog2(OVER_HOLD + 1);
  localparam logic [1:0] ITEM_LAST = 2'(N_ITEMS - 1);

  screen_e       state_q, state_d;
  logic [1:0]    item_q, item_d;
  logic [OW-1:0] over_q, over_d;
  logic          vblnk_q, p_over_q, p_over_d;
  logic          en_q, en_d, grst_q, grst_d, act_q, act_d;
  logic          tick;
  logic [3:0]    keys, pend;
  logic          ev_over, ev_esc, ev_enter, ev_ud, ev_up, ev_down;

  assign tick     = vblnk_in & ~vblnk_q;
  assign keys     = {key_esc, key_enter, key_down, key_up};
  assign p_over_d = tick ? game_over : (p_over_q | game_over);

  for (genvar i = 0; i < 4; i++) begin : g_key
`ifdef MENU_KEY_REPEAT_EN
    menu_key_edge #(
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE),
      .CAN_REPEAT  (i < 2)
    ) u_edge (
      .clk   (clk),
      .rst   (rst),
      .key_i (keys[i]),
      .tick_i(tick),
      .menu_i(state_q == SCR_MENU),
      .pend_o(pend[i])
    );
`else
    menu_key_edge u_edge (
      .clk   (clk),
      .rst   (rst),
      .key_i (keys[i]),
      .tick_i(tick),
      .pend_o(pend[i])
    );
`endif
  end

  always_comb begin
    state_d = state_q;
    item_d  = item_q;
    over_d  = over_q;
    grst_d  = 1'b0;
    act_d   = 1'b0;
    // Only the highest-priority pending event acts; opposing up/down cancel.
    ev_over  = p_over_q;
    ev_esc   = ~ev_over & pend[3];
    ev_enter = ~ev_over & ~pend[3] & pend[2];
    ev_ud    = ~ev_over & ~pend[3] & ~pend[2];
    ev_up    = ev_ud & pend[0] & ~pend[1];
    ev_down  = ev_ud & pend[1] & ~pend[0];
    if (tick) begin
      case (state_q)
        SCR_MENU: begin
          if (ev_enter) begin
            if (item_q == ITEM_START) begin
              state_d = SCR_GAME;
              grst_d  = 1'b1;
            end else begin
              act_d = 1'b1;
            end
          end else if (ev_up) begin
            item_d = (item_q == 2'd0) ? ITEM_LAST : item_q - 2'd1;
          end else if (ev_down) begin
            item_d = (item_q == ITEM_LAST) ? 2'd0 : item_q + 2'd1;
          end
        end
        SCR_GAME: begin
          if (ev_over) begin
            state_d = SCR_OVER;
            over_d  = '0;
          end else if (ev_esc) begin
            state_d = SCR_PAUSE;
          end
        end
        SCR_PAUSE: begin
          if (ev_over) begin
            state_d = SCR_OVER;
            over_d  = '0;
          end else if (ev_esc) begin
            state_d = SCR_GAME;
          end else if (ev_enter) begin
            state_d = SCR_MENU;
            item_d  = ITEM_START;
          end
        end
        SCR_OVER: begin
          over_d = over_q + 1'b1;
          if (ev_enter || (over_d >= OW'(OVER_HOLD - 1))) begin
            state_d = SCR_MENU;
            item_d  = ITEM_START;
            over_d  = '0;
          end
        end
        default: state_d = SCR_MENU;
      endcase
    end
    en_d = (state_d == SCR_GAME);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= SCR_MENU;
      item_q   <= ITEM_START;
      over_q   <= '0;
      vblnk_q  <= 1'b1;
      p_over_q <= 1'b0;
      en_q     <= 1'b0;
      grst_q   <= 1'b0;
      act_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      item_q   <= item_d;
      over_q   <= over_d;
      vblnk_q  <= vblnk_in;
      p_over_q <= p_over_d;
      en_q     <= en_d;
      grst_q   <= grst_d;
      act_q    <= act_d;
    end
  end

  assign screen_sel = state_q;
  assign item_sel   = item_q;
  assign game_en    = en_q;
  assign game_rst   = grst_q;
  assign item_act   = act_q;

endmodule
